cpu_divmod_unit: RTL and testbench

Parametrised, iterative non-restoring integer divider producing quotient and remainder. It replaces the separate fixed 32-bit and 64-bit divider instances in the CPU execute stage with one WIDTH-generic block. Compared with those instances it adds an explicit reset, a divide-by-zero/overflow status, a sticky result-hold and a one-command-at-a-time handshake. The CPU `StFinishExecInstr` state polls `data_ready` to end a multi-cycle divide.

---
 rtl/cpu_divmod_unit_pkg.sv | 26 ++
 rtl/cpu_divmod_unit_if.sv | 25 ++
 rtl/cpu_divmod_unit_nr_step.sv | 21 ++
 rtl/cpu_divmod_unit.sv | 147 ++++++++++++++
 tb/tb_cpu_divmod_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_divmod_unit_pkg.sv
// Shared types and helpers for the iterative non-restoring divide/modulo unit.
package pkg_divmod;

    typedef enum logic [1:0] {
        StDmIdle,
        StDmPrep,
        StDmIter,
        StDmFixup
    } DivmodState;

    // Widest operand the magnitude helper handles; callers cast in and out.
    localparam int DM_MAX_WIDTH = 128;

    // Iteration counter width: WIDTH-1 must fit in the counter.
    function automatic int dm_cnt_width(input int width);
        return $clog2(width);
    endfunction

    function automatic logic [DM_MAX_WIDTH-1:0] dm_magnitude(
        input logic [DM_MAX_WIDTH-1:0] value,
        input logic                    negative
    );
        return negative ? (~value + DM_MAX_WIDTH'(1)) : value;
    endfunction

endpackage

// File: rtl/cpu_divmod_unit_if.sv
// Command/result bundle between the CPU execute stage (master) and the divider (slave).
interface cpu_divmod_unit_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic             unsgn_or_sgn;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] denom;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_by_zero;
    logic             sgn_overflow;
    logic             can_accept_cmd;
    logic             data_ready;

    modport master (
        output enable, unsgn_or_sgn, num, denom,
        input  quot, rem, div_by_zero, sgn_overflow, can_accept_cmd, data_ready
    );

    modport slave (
        input  enable, unsgn_or_sgn, num, denom,
        output quot, rem, div_by_zero, sgn_overflow, can_accept_cmd, data_ready
    );
endinterface

// File: rtl/cpu_divmod_unit_nr_step.sv
// One combinational non-restoring iteration: shift {P,Q} left, add/subtract D, set Q LSB.
module divmod_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_out,
    output logic [WIDTH-1:0] q_out
);
    logic [WIDTH:0] p_shift;
    logic [WIDTH:0] d_ext;

    // P may wrap on the shift; the add/sub brings it back into [-D, D).
    always_comb begin
        p_shift = {p_in[WIDTH-1:0], q_in[WIDTH-1]};
        d_ext   = {1'b0, d};
        p_out   = p_in[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
        q_out   = {q_in[WIDTH-2:0], ~p_out[WIDTH]};
    end
endmodule

// File: rtl/cpu_divmod_unit.sv
// WIDTH-generic iterative signed/unsigned divider with quotient, remainder and status.
// Optional macro CPU_DIVMOD_EARLY_OUT_EN: skip iterations for zero, MIN/-1 and |num|<|denom|.
module cpu_divmod_unit
    import pkg_divmod::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_divmod_unit_if.slave bus
);
    localparam int CNT_W = dm_cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    DivmodState       state, state_nxt;
    logic             sgn_r;
    logic [WIDTH-1:0] num_r, denom_r, d_r, q_r;
    logic [WIDTH:0]   p_r;
    logic             q_neg, r_neg, dz_r, ovf_r;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] num_mag, den_mag, q_step, rem_mag, fix_quot, fix_rem;
    logic [WIDTH:0]   p_step;
    logic             prep_dz, prep_ovf, early_exit;

    // NOTE: every signal written in always_comb gets a value before any branch, so no latch is inferred.
    always_comb begin
        num_mag  = WIDTH'(dm_magnitude(DM_MAX_WIDTH'(num_r), sgn_r & num_r[WIDTH-1]));
        den_mag  = WIDTH'(dm_magnitude(DM_MAX_WIDTH'(denom_r), sgn_r & denom_r[WIDTH-1]));
        prep_dz  = (denom_r == '0);
        prep_ovf = sgn_r && (num_r == MIN_VAL) && (denom_r == '1);
    end

`ifdef CPU_DIVMOD_EARLY_OUT_EN
    assign early_exit = prep_dz | prep_ovf | (num_mag < den_mag);
`else
    assign early_exit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= StDmIdle;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            StDmIdle:  if (bus.enable) state_nxt = StDmPrep;
            StDmPrep:  state_nxt = early_exit ? StDmFixup : StDmIter;
            StDmIter:  if (cnt == '0) state_nxt = StDmFixup;
            StDmFixup: state_nxt = StDmIdle;
            default:   state_nxt = StDmIdle;
        endcase
    end

    assign bus.can_accept_cmd = (state == StDmIdle);

    divmod_nr_step #(.WIDTH(WIDTH)) u_step (
        .p_in  (p_r),
        .q_in  (q_r),
        .d     (d_r),
        .p_out (p_step),
        .q_out (q_step)
    );

    // Restore a negative partial remainder, then apply signs or the special-case overrides.
    always_comb begin
        rem_mag = WIDTH'(p_r[WIDTH] ? (p_r + {1'b0, d_r}) : p_r);
        if (dz_r) begin
            fix_quot = '1;
            fix_rem  = num_r;
        end else if (ovf_r) begin
            fix_quot = MIN_VAL;
            fix_rem  = '0;
        end else begin
            fix_quot = q_neg ? -q_r : q_r;
            fix_rem  = r_neg ? -rem_mag : rem_mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_r   <= 1'b0;
            num_r   <= '0;
            denom_r <= '0;
            d_r     <= '0;
            p_r     <= '0;
            q_r     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz_r    <= 1'b0;
            ovf_r   <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (state)
                StDmIdle: begin
                    if (bus.enable) begin
                        sgn_r   <= bus.unsgn_or_sgn;
                        num_r   <= bus.num;
                        denom_r <= bus.denom;
                    end
                end
                StDmPrep: begin
                    q_neg <= sgn_r & (num_r[WIDTH-1] ^ denom_r[WIDTH-1]);
                    r_neg <= sgn_r & num_r[WIDTH-1];
                    dz_r  <= prep_dz;
                    ovf_r <= prep_ovf;
                    d_r   <= den_mag;
                    cnt   <= CNT_W'(WIDTH - 1);
                    if (early_exit) begin
                        p_r <= {1'b0, num_mag};
                        q_r <= '0;
                    end else begin
                        p_r <= '0;
                        q_r <= num_mag;
                    end
                end
                StDmIter: begin
                    p_r <= p_step;
                    q_r <= q_step;
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.quot         <= '0;
            bus.rem          <= '0;
            bus.div_by_zero  <= 1'b0;
            bus.sgn_overflow <= 1'b0;
            bus.data_ready   <= 1'b0;
        end else begin
            bus.data_ready <= (state == StDmFixup);
            if (state == StDmFixup) begin
                bus.quot         <= fix_quot;
                bus.rem          <= fix_rem;
                bus.div_by_zero  <= dz_r;
                bus.sgn_overflow <= ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_cpu_divmod_unit.sv
// Directed and randomised checks of cpu_divmod_unit at WIDTH=32 and WIDTH=64.
module tb_cpu_divmod_unit;

`ifdef CPU_DIVMOD_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    cpu_divmod_unit_if #(.WIDTH(32)) b32 ();
    cpu_divmod_unit_if #(.WIDTH(64)) b64 ();

    cpu_divmod_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
    cpu_divmod_unit #(.WIDTH(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int exp_lat32(input bit special);
        return (EARLY && special) ? 2 : 34;
    endfunction

    // Edges counted after the accepting edge until data_ready is seen; -1 on timeout.
    task automatic wait_ready32(output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (b32.data_ready) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run32(input logic sgn, input logic [31:0] n, input logic [31:0] d, output int lat);
        @(negedge clk);
        b32.enable       = 1'b1;
        b32.unsgn_or_sgn = sgn;
        b32.num          = n;
        b32.denom        = d;
        @(posedge clk);
        #1 b32.enable = 1'b0;
        wait_ready32(lat);
    endtask

    task automatic div32(input string tag, input logic sgn, input logic [31:0] n, input logic [31:0] d,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz, input logic eov,
                         input bit special);
        int lat;
        run32(sgn, n, d, lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat32(special)));
        check({tag, " quot/rem"}, {b32.quot, b32.rem}, {eq, er});
        check({tag, " flags"}, 64'({b32.div_by_zero, b32.sgn_overflow}), 64'({edz, eov}));
    endtask

    function automatic void ref32(input logic sgn, input logic [31:0] n, input logic [31:0] d,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output logic ov);
        int sn, sd;
        sn = n;
        sd = d;
        dz = 1'b0;
        ov = 1'b0;
        if (d == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = n;
            dz = 1'b1;
        end else if (sgn && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
            q  = n;
            r  = 32'd0;
            ov = 1'b1;
        end else if (sgn) begin
            q = 32'(sn / sd);
            r = 32'(sn % sd);
        end else begin
            q = n / d;
            r = n % d;
        end
    endfunction

    initial begin
        int lat;
        int pulses;
        logic [31:0] eq, er;
        logic edz, eov;

        rst_n            = 1'b0;
        b32.enable       = 1'b0;
        b32.unsgn_or_sgn = 1'b0;
        b32.num          = '0;
        b32.denom        = '0;
        b64.enable       = 1'b0;
        b64.unsgn_or_sgn = 1'b0;
        b64.num          = '0;
        b64.denom        = '0;
        repeat (3) @(negedge clk);
        check("reset quot/rem", {b32.quot, b32.rem}, 64'd0);
        check("reset status", 64'({b32.div_by_zero, b32.sgn_overflow, b32.data_ready}), 64'd0);
        check("reset can_accept", 64'(b32.can_accept_cmd), 64'd1);
        rst_n = 1'b1;

        // Basic unsigned and signed operation.
        div32("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check("data_ready single cycle", 64'(b32.data_ready), 64'd0);
        div32("s -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        div32("s 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, 1'b0);
        div32("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // Special cases and unsigned boundaries.
        div32("u 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1'b1);
        div32("s -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b1);
        div32("s MIN/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b1);
        div32("u MAX/MAX", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        div32("u MIN/MAX", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        div32("u 3/10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b0, 1'b1);

        // enable held high: mid-operation command ignored, back-to-back accepted on data_ready edge.
        @(negedge clk);
        b32.enable       = 1'b1;
        b32.unsgn_or_sgn = 1'b0;
        b32.num          = 32'd1000;
        b32.denom        = 32'd10;
        @(posedge clk);
        #1;
        b32.unsgn_or_sgn = 1'b1;
        b32.num          = 32'hFFFF_FFF9;
        b32.denom        = 32'd2;
        wait_ready32(lat);
        check("held A latency", 64'(lat), 64'd34);
        check("held A quot/rem", {b32.quot, b32.rem}, {32'd100, 32'd0});
        @(posedge clk);
        #1 b32.enable = 1'b0;
        wait_ready32(lat);
        check("b2b B latency", 64'(lat), 64'd34);
        check("b2b B quot/rem", {b32.quot, b32.rem}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});

        // Reset during ITER cycle 10.
        @(negedge clk);
        b32.enable       = 1'b1;
        b32.unsgn_or_sgn = 1'b0;
        b32.num          = 32'd12345;
        b32.denom        = 32'd67;
        @(posedge clk);
        #1 b32.enable = 1'b0;
        repeat (11) @(posedge clk);
        #1 check("busy in ITER", 64'(b32.can_accept_cmd), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid-op reset quot/rem", {b32.quot, b32.rem}, 64'd0);
        check("mid-op reset can_accept", 64'(b32.can_accept_cmd), 64'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (b32.data_ready) pulses++;
        end
        check("no pulse after reset", 64'(pulses), 64'd0);
        div32("u MAX/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0, 1'b0);

        // WIDTH=64 signed.
        @(negedge clk);
        b64.enable       = 1'b1;
        b64.unsgn_or_sgn = 1'b1;
        b64.num          = 64'h8000_0000_0000_0001;
        b64.denom        = 64'd3;
        @(posedge clk);
        #1 b64.enable = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (b64.data_ready) begin
                lat = i;
                break;
            end
        end
        check("w64 latency", 64'(lat), 64'd66);
        check("w64 quot", b64.quot, 64'hD555_5555_5555_5556);
        check("w64 rem", b64.rem, 64'hFFFF_FFFF_FFFF_FFFF);

        // Random sweep against a behavioural reference.
        for (int v = 0; v < 250; v++) begin
            logic        sgn;
            logic [31:0] n, d;
            sgn = 1'($urandom_range(0, 1));
            n   = (v % 17 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       d = $urandom;
                1:       d = $urandom >> $urandom_range(1, 31);
                2:       d = 32'($urandom_range(0, 3));
                3:       d = 32'hFFFF_FFFF;
                default: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            endcase
            ref32(sgn, n, d, eq, er, edz, eov);
            run32(sgn, n, d, lat);
            check($sformatf("rand %0d %h/%h quot/rem", v, n, d), {b32.quot, b32.rem}, {eq, er});
            check($sformatf("rand %0d flags", v), 64'({b32.div_by_zero, b32.sgn_overflow}), 64'({edz, eov}));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
